cf_fft_1024_8_phase_seq: RTL and testbench
==========================================

// Module: cf_fft_1024_8_phase_seq
// PURPOSE
//  Phase/sequence controller for the 1024-point, 8-bit FFT datapath. Produces the 3-bit
//  phase select that drives the per-stage operand muxes (decodes 3'b010/100/110 pick
//  operands; other codes give the constant-1 default), plus butterfly index and stage
//  number. Sits directly upstream of the operand-select muxes. Start/busy/done handshake
//  to the FFT top-level control.
// PARAMETERS
//  LOG2N     10  log2 of transform length; butterflies per stage = 2**(LOG2N-1), stages = LOG2N
//  PHASE_W   3   width of phase select; phases per butterfly = 2**PHASE_W (8)
// PORTS
//  clock_c   in   1        single clock, all state on rising edge
//  reset     in   1        asynchronous, active-high; clears all state
//  start     in   1        request a transform; sampled in IDLE or DONE only
//  en        in   1        advance enable; low freezes all counters (stall), outputs hold
//  phase     out  PHASE_W  phase select to operand muxes
//  bfly      out  LOG2N-1  butterfly index within current stage
//  stage     out  4        current stage, 0..LOG2N-1
//  first     out  1        high when phase==0 in RUN (butterfly boundary strobe)
//  busy      out  1        high in RUN
//  done      out  1        one-cycle pulse after last phase of last butterfly of last stage
// BEHAVIOUR
//  - Reset: state=IDLE, phase=0, bfly=0, stage=0, first=0, busy=0, done=0. Reset mid-RUN
//    aborts immediately; no done pulse.
//  - States: IDLE, RUN, DONE (2-bit encoded).
//    IDLE: start=1 -> RUN next cycle with all counters 0; busy rises the same edge.
//    RUN: on each cycle with en=1 phase increments mod 2**PHASE_W; on phase wrap
//      (7->0) bfly increments; on bfly wrap (511->0) stage increments. At phase=7,
//      bfly=511, stage=LOG2N-1 with en=1 -> DONE, counters cleared to 0.
//    DONE: done=1 for exactly one cycle, busy=0. start=1 here -> RUN (back-to-back);
//      else -> IDLE. en ignored in DONE.
//  - start while RUN is ignored (no restart, no error flag).
//  - en=0 in RUN: phase/bfly/stage/first hold; the terminal transition does not occur
//    until en=1 on the terminal count.
//  - All outputs registered (Moore); phase change visible one cycle after the en that
//    caused it. first = busy & (phase==0), decoded from registered state.
//  - Total enabled RUN cycles per transform: LOG2N * 2**(LOG2N-1) * 2**PHASE_W
//    = 40960 at defaults. Counters are unsigned, wrap modulo their width; no saturation.
// STRUCTURE
//  - Package cf_fft_1024_8_pkg: LOG2N, PHASE_W, derived BFLY_W, NUM_STAGES, state
//    encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, phase decode constants
//    3'b010/3'b100/3'b110 shared with the operand-select muxes.
//  - Sub-module cf_fft_1024_8_wrap_cnt (W, MAX): clr, inc in; q, wrap out (wrap = inc &
//    q==MAX). Instantiated three times, chained by wrap (phase -> bfly -> stage).
//  - FSM and output registers in the top module.
// TESTING
//  1 Reset then start=1 one cycle, en=1 -> busy=1 next cycle, phase 0..7 repeating,
//    bfly=1 at cycle 8, stage=1 at cycle 4096, done pulse after cycle 40960, busy=0.
//  2 en toggled 1/0 every cycle in RUN -> phase advances every 2 cycles; done after
//    81920 cycles; no counter moves while en=0.
//  3 start held high continuously -> done pulse then immediately RUN with counters 0;
//    start pulses mid-RUN leave phase/bfly/stage sequence unchanged.
//  4 reset asserted asynchronously at stage=3, bfly=100, phase=5 -> all outputs 0
//    without waiting for clock; no done; after release IDLE until start.
//  5 Phase decode check: count cycles with phase in {2,4,6} per butterfly = 3, and
//    first=1 exactly once per butterfly (5120 per transform).

Source files
------------

// File: rtl/cf_fft_1024_8_phase_seq_pkg.sv
// Shared constants for the FFT phase/sequence controller and the operand-select muxes.
package cf_fft_1024_8_pkg;

  localparam int LOG2N      = 10;
  localparam int PHASE_W    = 3;
  localparam int BFLY_W     = LOG2N - 1;
  localparam int NUM_STAGES = LOG2N;
  localparam int STAGE_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Phase codes that select real operands; every other code yields the constant-1 default.
  localparam logic [2:0] PH_OPA = 3'b010;
  localparam logic [2:0] PH_OPB = 3'b100;
  localparam logic [2:0] PH_OPC = 3'b110;

  function automatic logic ph_is_operand(input logic [2:0] ph);
    return (ph == PH_OPA) || (ph == PH_OPB) || (ph == PH_OPC);
  endfunction

endpackage

// File: rtl/cf_fft_1024_8_phase_seq_if.sv
// Handshake and sequence outputs between the FFT control and the phase sequencer.
interface cf_fft_1024_8_phase_seq_if #(
  parameter int LOG2N   = 10,
  parameter int PHASE_W = 3
);
  logic               start;
  logic               en;
  logic [PHASE_W-1:0] phase;
  logic [LOG2N-2:0]   bfly;
  logic [3:0]         stage;
  logic               first;
  logic               busy;
  logic               done;

  modport master (
    output start, en,
    input  phase, bfly, stage, first, busy, done
  );

  modport slave (
    input  start, en,
    output phase, bfly, stage, first, busy, done
  );
endinterface

// File: rtl/cf_fft_1024_8_phase_seq_wrap_cnt.sv
// Modulo-(MAX+1) counter with synchronous clear and a wrap strobe for chaining.
module cf_fft_1024_8_wrap_cnt #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         wrap
);

  assign wrap = inc & (q == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= wrap ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/cf_fft_1024_8_phase_seq.sv
// Phase/butterfly/stage sequencer for the FFT datapath with start/busy/done handshake.
module cf_fft_1024_8_phase_seq
  import cf_fft_1024_8_pkg::*;
#(
  parameter int LOG2N   = cf_fft_1024_8_pkg::LOG2N,
  parameter int PHASE_W = cf_fft_1024_8_pkg::PHASE_W
) (
  input  logic                      clock_c,
  input  logic                      reset,
  cf_fft_1024_8_phase_seq_if.slave  bus
);

  state_t             state_q, state_d;
  logic               run_en;
  logic               cnt_clr;
  logic               phase_wrap, bfly_wrap, stage_wrap;
  logic [PHASE_W-1:0] phase_q;
  logic [LOG2N-2:0]   bfly_q;
  logic [3:0]         stage_q;

  assign run_en  = (state_q == ST_RUN) & bus.en;
  // Counters sit at zero outside RUN and are cleared on the terminal count.
  assign cnt_clr = (state_q != ST_RUN) | stage_wrap;

  cf_fft_1024_8_wrap_cnt #(.W(PHASE_W), .MAX((1 << PHASE_W) - 1)) u_phase (
    .clk (clock_c), .rst (reset), .clr (cnt_clr), .inc (run_en),
    .q   (phase_q), .wrap (phase_wrap)
  );

  cf_fft_1024_8_wrap_cnt #(.W(LOG2N - 1), .MAX((1 << (LOG2N - 1)) - 1)) u_bfly (
    .clk (clock_c), .rst (reset), .clr (cnt_clr), .inc (phase_wrap),
    .q   (bfly_q), .wrap (bfly_wrap)
  );

  cf_fft_1024_8_wrap_cnt #(.W(4), .MAX(LOG2N - 1)) u_stage (
    .clk (clock_c), .rst (reset), .clr (cnt_clr), .inc (bfly_wrap),
    .q   (stage_q), .wrap (stage_wrap)
  );

  always_ff @(posedge clock_c or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (stage_wrap) state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.phase = phase_q;
  assign bus.bfly  = bfly_q;
  assign bus.stage = stage_q;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.first = (state_q == ST_RUN) & (phase_q == '0);

endmodule

// File: tb/tb_cf_fft_1024_8_phase_seq.sv
// Scoreboard bench for the FFT phase sequencer, using a reduced transform length.
module tb_cf_fft_1024_8_phase_seq;
  import cf_fft_1024_8_pkg::*;

  localparam int TB_LOG2N = 8;
  localparam int TB_PW    = 3;
  localparam int NPH      = 1 << TB_PW;
  localparam int NB       = 1 << (TB_LOG2N - 1);
  localparam int TOTAL    = TB_LOG2N * NB * NPH;

  typedef struct packed {
    logic [TB_PW-1:0]    phase;
    logic [TB_LOG2N-2:0] bfly;
    logic [3:0]          stage;
    logic                first;
    logic                busy;
    logic                done;
  } obs_t;

  logic clock_c = 1'b0;
  logic reset   = 1'b0;

  cf_fft_1024_8_phase_seq_if #(.LOG2N(TB_LOG2N), .PHASE_W(TB_PW)) bus ();

  cf_fft_1024_8_phase_seq #(.LOG2N(TB_LOG2N), .PHASE_W(TB_PW)) dut (
    .clock_c (clock_c),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clock_c = ~clock_c;

  obs_t sbq[$];
  int   m_state;
  int   m_idx;
  int   n_tests;
  int   n_fail;
  bit   collect;
  int   op_cnt, first_cnt, done_cnt;

  // Reference outputs from a flat count of enabled RUN cycles.
  function automatic obs_t model_out();
    obs_t e;
    e.phase = TB_PW'(m_idx % NPH);
    e.bfly  = (TB_LOG2N - 1)'((m_idx / NPH) % NB);
    e.stage = 4'(m_idx / (NPH * NB));
    e.busy  = (m_state == 1);
    e.done  = (m_state == 2);
    e.first = e.busy && (m_idx % NPH == 0);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.phase = bus.phase;
    o.bfly  = bus.bfly;
    o.stage = bus.stage;
    o.first = bus.first;
    o.busy  = bus.busy;
    o.done  = bus.done;
    return o;
  endfunction

  task automatic model_step(input logic s, input logic e);
    case (m_state)
      0: if (s) begin m_state = 1; m_idx = 0; end
      1: if (e) begin
           if (m_idx == TOTAL - 1) begin m_state = 2; m_idx = 0; end
           else m_idx = m_idx + 1;
         end
      default: begin m_state = s ? 1 : 0; m_idx = 0; end
    endcase
  endtask

  task automatic cycle(input string name, input logic s, input logic e);
    obs_t exp_o, got;
    bus.start = s;
    bus.en    = e;
    model_step(s, e);
    sbq.push_back(model_out());
    @(posedge clock_c);
    #1;
    exp_o = sbq.pop_front();
    got   = sample();
    n_tests++;
    if (got !== exp_o) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s t=%0t got ph=%0d bf=%0d st=%0d f=%b b=%b d=%b expected ph=%0d bf=%0d st=%0d f=%b b=%b d=%b",
                 name, $time, got.phase, got.bfly, got.stage, got.first, got.busy, got.done,
                 exp_o.phase, exp_o.bfly, exp_o.stage, exp_o.first, exp_o.busy, exp_o.done);
    end
    if (got.done) done_cnt++;
    if (collect && got.busy) begin
      if (got.phase == 3'd2 || got.phase == 3'd4 || got.phase == 3'd6) op_cnt++;
      if (got.first) first_cnt++;
    end
  endtask

  task automatic check_now(input string name);
    obs_t exp_o, got;
    sbq.push_back(model_out());
    exp_o = sbq.pop_front();
    got   = sample();
    n_tests++;
    if (got !== exp_o) begin
      n_fail++;
      $display("FAIL %s t=%0t got ph=%0d bf=%0d st=%0d f=%b b=%b d=%b expected all zero",
               name, $time, got.phase, got.bfly, got.stage, got.first, got.busy, got.done);
    end
  endtask

  task automatic check_count(input string name, input int got, input int exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.en    = 1'b0;
    #1 reset = 1'b1;
    m_state = 0; m_idx = 0;
    #1 check_now("reset_async");
    @(posedge clock_c);
    #1 check_now("reset_held");
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle("idle_after_reset", 1'b0, 1'b1);
  endtask

  task automatic test_full_run();
    collect = 1'b1; op_cnt = 0; first_cnt = 0; done_cnt = 0;
    cycle("run_start", 1'b1, 1'b1);
    for (int i = 0; i < TOTAL; i++) cycle("run_seq", 1'b0, 1'b1);
    cycle("run_to_idle", 1'b0, 1'b1);
    collect = 1'b0;
    check_count("operand_phases", op_cnt, 3 * NB * TB_LOG2N);
    check_count("first_strobes", first_cnt, NB * TB_LOG2N);
    check_count("run_done_pulses", done_cnt, 1);
  endtask

  task automatic test_en_toggle();
    done_cnt = 0;
    cycle("stall_start", 1'b1, 1'b0);
    for (int i = 0; i < 2 * TOTAL; i++) cycle("stall_seq", 1'b0, (i % 2) == 0);
    cycle("stall_done", 1'b0, 1'b0);
    cycle("stall_idle", 1'b0, 1'b0);
    check_count("stall_done_pulses", done_cnt, 1);
  endtask

  task automatic test_back_to_back();
    done_cnt = 0;
    for (int i = 0; i < 2 * TOTAL + 40; i++) cycle("b2b_seq", 1'b1, 1'b1);
    check_count("b2b_done_pulses", done_cnt, 2);
  endtask

  task automatic test_async_reset();
    int target;
    bit hit;
    target = 3 * NB * NPH + 100 * NPH + 5;
    #2 reset = 1'b1;
    m_state = 0; m_idx = 0;
    #1 check_now("abort_b2b");
    #2 reset = 1'b0;
    done_cnt = 0;
    hit = 1'b0;
    cycle("ar_start", 1'b1, 1'b1);
    for (int i = 0; i < TOTAL && !hit; i++) begin
      cycle("ar_seq", 1'b0, 1'b1);
      if (m_state == 1 && m_idx == target) hit = 1'b1;
    end
    check_count("ar_reached_target", int'(hit), 1);
    #2 reset = 1'b1;
    m_state = 0; m_idx = 0;
    #1 check_now("ar_mid_run");
    @(posedge clock_c);
    #1 check_now("ar_held");
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle("ar_idle", 1'b0, 1'b1);
    check_count("ar_no_done", done_cnt, 0);
    cycle("ar_restart", 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle("ar_rerun", 1'b0, 1'b1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; collect = 1'b0;
    m_state = 0; m_idx = 0;
    op_cnt = 0; first_cnt = 0; done_cnt = 0;
    test_reset();
    test_full_run();
    test_en_toggle();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
